// File: rtl/pwm_generator.sv
// -----------------------------------------------------------------------------
// pwm_generator
//
// Fixed-frequency PWM stage driven by the PID regulator's duty command.
// A prescaler divides clk_27 into ticks. A 15-bit period counter runs
// 0..PERIOD on those ticks, giving a period of PERIOD+1 ticks. The duty
// command is clamped to PERIOD and latched only at the period wrap, so a
// period never sees a half-applied duty change.
//
// Parameters:
//   PERIOD   - terminal count of the period counter (period = PERIOD+1 ticks)
//   PRESCALE - clk_27 cycles per tick, 1..65535
//   DEADTIME - dead-time in clk_27 cycles, 1..255 (dead-time build only)
//
// Ports:
//   clk_27       in   system clock, all logic on the rising edge
//   areset       in   asynchronous, active-low reset
//   u_in[14:0]   in   duty command (unsigned)
//   en           in   run enable; while low the outputs are off and duty_q
//                     tracks the clamped u_in
//   pwm_out      out  high-side drive (registered)
//   pwm_n        out  complementary low-side drive (constant 0 unless the
//                     dead-time build is selected)
//   period_start out  one-cycle strobe in the cycle cnt=0 first becomes
//                     visible, and in the first cycle after en rises
//   duty_q[14:0] out  duty value currently applied
//
// Build option:
//   PWM_DEADTIME_EN - when defined, adds dead-time insertion and the
//                     complementary pwm_n output.
// -----------------------------------------------------------------------------
module pwm_generator #(
    parameter logic [14:0] PERIOD   = 15'd32767,
    parameter int unsigned PRESCALE = 1,
    parameter int unsigned DEADTIME = 8
) (
    input  logic        clk_27,
    input  logic        areset,
    input  logic [14:0] u_in,
    input  logic        en,
    output logic        pwm_out,
    output logic        pwm_n,
    output logic        period_start,
    output logic [14:0] duty_q
);

    if (PRESCALE < 1 || PRESCALE > 65535 || DEADTIME < 1 || DEADTIME > 255) begin : g_param_check
        $error("pwm_generator: PRESCALE or DEADTIME out of range");
    end

    localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);

    logic [15:0] presc;
    logic [14:0] cnt;
    logic        en_d;

    logic        run;
    logic        tick;
    logic        wrap;
    logic        raw;
    logic [14:0] u_clamped;

    // NOTE: every signal is assigned unconditionally here, so no latch can be
    // inferred for any of them.
    always_comb begin
        // The first enabled cycle is spent presenting cnt=0 with the
        // period_start strobe; counting begins on the cycle after, which keeps
        // the first period exactly as long as every later one.
        run       = en & en_d;
        tick      = run && (presc == PRESC_LAST);
        wrap      = tick && (cnt == PERIOD);
        u_clamped = (u_in > PERIOD) ? PERIOD : u_in;
        raw       = run && (cnt < duty_q);
    end

    // NOTE: state registers use non-blocking assignments and an asynchronous
    // active-low clear, so every flop sees pre-edge values of its neighbours.
    always_ff @(posedge clk_27 or negedge areset) begin
        if (!areset) begin
            presc        <= '0;
            cnt          <= '0;
            en_d         <= 1'b0;
            duty_q       <= '0;
            period_start <= 1'b0;
        end else begin
            en_d <= en;

            if (!run) begin
                presc <= '0;
                cnt   <= '0;
            end else begin
                presc <= tick ? 16'd0 : presc + 16'd1;
                if (tick) begin
                    cnt <= wrap ? 15'd0 : cnt + 15'd1;
                end
            end

            // Idle: track the command continuously. Running: only at the wrap.
            if (!en || wrap) begin
                duty_q <= u_clamped;
            end

            period_start <= en && (wrap || !en_d);
        end
    end

`ifdef PWM_DEADTIME_EN
    localparam logic [7:0] DT = 8'(DEADTIME);

    logic       lo_raw;
    logic [7:0] hi_cnt;
    logic [7:0] lo_cnt;

    assign lo_raw = run && !raw;

    // hi_cnt/lo_cnt count consecutive cycles of raw high/low, saturating at
    // DT. An output is driven only once its side has been stable for DT
    // cycles, so short pulses vanish and both sides can never be on together
    // (each needs raw at the opposite level on the same edge).
    always_ff @(posedge clk_27 or negedge areset) begin
        if (!areset) begin
            hi_cnt  <= '0;
            lo_cnt  <= '0;
            pwm_out <= 1'b0;
            pwm_n   <= 1'b0;
        end else begin
            if (raw) begin
                hi_cnt <= (hi_cnt == DT) ? DT : hi_cnt + 8'd1;
            end else begin
                hi_cnt <= '0;
            end

            if (lo_raw) begin
                lo_cnt <= (lo_cnt == DT) ? DT : lo_cnt + 8'd1;
            end else begin
                lo_cnt <= '0;
            end

            pwm_out <= raw && (hi_cnt == DT);
            pwm_n   <= lo_raw && (lo_cnt == DT);
        end
    end
`else
    always_ff @(posedge clk_27 or negedge areset) begin
        if (!areset) begin
            pwm_out <= 1'b0;
        end else begin
            pwm_out <= raw;
        end
    end

    assign pwm_n = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_generator.sv
// -----------------------------------------------------------------------------
// tb_pwm_generator
//
// Directed bench for pwm_generator. Two instances share clk_27 and areset:
//   dut  - PERIOD=99, PRESCALE=1, DEADTIME=8 (100-cycle period)
//   dut4 - PERIOD=9,  PRESCALE=4, DEADTIME=8 (40-cycle period)
// Outputs are sampled on the falling edge of clk_27. Windows are aligned to
// period_start, so a window of one full period covers exactly one pulse.
// Expected values are hand-derived; the dead-time build is selected with the
// same PWM_DEADTIME_EN macro as the design.
// -----------------------------------------------------------------------------
module tb_pwm_generator;

    logic        clk_27;
    logic        areset;
    logic        en;
    logic        en4;
    logic [14:0] u_in;
    logic [14:0] u4;

    logic        pwm_out, pwm_n, period_start;
    logic [14:0] duty_q;
    logic        pwm_out_4, pwm_n_4, period_start_4;
    logic [14:0] duty_q_4;

    int n_checks = 0;
    int n_fail   = 0;

    logic        sel = 1'b0;
    logic        s_pwm, s_n, s_ps;
    logic [14:0] s_duty;

    pwm_generator #(.PERIOD(15'd99), .PRESCALE(1), .DEADTIME(8)) dut (
        .clk_27       (clk_27),
        .areset       (areset),
        .u_in         (u_in),
        .en           (en),
        .pwm_out      (pwm_out),
        .pwm_n        (pwm_n),
        .period_start (period_start),
        .duty_q       (duty_q)
    );

    pwm_generator #(.PERIOD(15'd9), .PRESCALE(4), .DEADTIME(8)) dut4 (
        .clk_27       (clk_27),
        .areset       (areset),
        .u_in         (u4),
        .en           (en4),
        .pwm_out      (pwm_out_4),
        .pwm_n        (pwm_n_4),
        .period_start (period_start_4),
        .duty_q       (duty_q_4)
    );

    initial clk_27 = 1'b0;
    always #5 clk_27 = ~clk_27;

    always_comb begin
        s_pwm  = sel ? pwm_out_4      : pwm_out;
        s_n    = sel ? pwm_n_4        : pwm_n;
        s_ps   = sel ? period_start_4 : period_start;
        s_duty = sel ? duty_q_4       : duty_q;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Expected high-side cycles for a raw high run of d cycles.
    function automatic int exp_hi(int d);
`ifdef PWM_DEADTIME_EN
        return (d >= 8) ? d - 8 : 0;
`else
        return d;
`endif
    endfunction

    // Expected low-side cycles in a window of len cycles with a raw low run of lo.
    function automatic int exp_n(int lo, int len);
`ifdef PWM_DEADTIME_EN
        if (lo == len) return len;
        return (lo >= 8) ? lo - 8 : 0;
`else
        return 0;
`endif
    endfunction

    // Advance at least one sample and stop on the next period_start.
    task automatic wait_ps(output int gap);
        gap = 0;
        do begin
            @(negedge clk_27);
            gap++;
        end while (!s_ps && gap < 1000);
        if (!s_ps) check("ps_wait", 32'(s_ps), 32'd1);
    endtask

    // Measure one window of len samples starting at the next period_start.
    task automatic measure(input int len, input int change_at, input logic [14:0] new_u,
                           output int hi, output int nh, output int ps, output int ovl,
                           output int gap, output logic [14:0] dq_first,
                           output logic [14:0] dq_last);
        hi = 0; nh = 0; ps = 0; ovl = 0;
        wait_ps(gap);
        dq_first = s_duty;
        dq_last  = s_duty;
        for (int k = 0; k < len; k++) begin
            if (k > 0) @(negedge clk_27);
            if (k == change_at) u_in = new_u;
            hi  += int'(s_pwm);
            nh  += int'(s_n);
            ps  += int'(s_ps);
            ovl += int'(s_pwm & s_n);
            dq_last = s_duty;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi, nh, ps, ovl, gap;
        logic [14:0] dq0, dq1;

        areset = 1'b0;
        en     = 1'b0;
        en4    = 1'b0;
        u_in   = 15'd25;
        u4     = 15'd5;

        // Reset state.
        repeat (3) @(negedge clk_27);
        check("rst_pwm_out", 32'(pwm_out), 32'd0);
        check("rst_pwm_n", 32'(pwm_n), 32'd0);
        check("rst_period_start", 32'(period_start), 32'd0);
        check("rst_duty_q", 32'(duty_q), 32'd0);

        // Idle after release: duty tracks u_in, no output activity.
        areset = 1'b1;
        repeat (3) @(negedge clk_27);
        check("idle_duty_q", 32'(duty_q), 32'd25);
        check("idle_pwm_out", 32'(pwm_out), 32'd0);
        check("idle_period_start", 32'(period_start), 32'd0);

        // Enable: strobe in the first cycle, output still low.
        en = 1'b1;
        @(negedge clk_27);
        check("start_period_start", 32'(period_start), 32'd1);
        check("start_pwm_out", 32'(pwm_out), 32'd0);
        check("start_duty_q", 32'(duty_q), 32'd25);

        // u_in=25: 100-cycle period, 25 cycles high.
        measure(100, -1, 15'd0, hi, nh, ps, ovl, gap, dq0, dq1);
        check("d25_first_gap", 32'(gap), 32'd100);
        check("d25_hi", 32'(hi), 32'(exp_hi(25)));
        check("d25_n", 32'(nh), 32'(exp_n(75, 100)));
        check("d25_ps_count", 32'(ps), 32'd1);
        check("d25_overlap", 32'(ovl), 32'd0);

        // u_in 25->60 at cnt=40: this period unaffected, next one at 60.
        measure(100, 40, 15'd60, hi, nh, ps, ovl, gap, dq0, dq1);
        check("chg_gap", 32'(gap), 32'd1);
        check("chg_hi", 32'(hi), 32'(exp_hi(25)));
        check("chg_duty_end", 32'(dq1), 32'd25);
        measure(100, -1, 15'd0, hi, nh, ps, ovl, gap, dq0, dq1);
        check("d60_duty_at_wrap", 32'(dq0), 32'd60);
        check("d60_hi", 32'(hi), 32'(exp_hi(60)));
        check("d60_n", 32'(nh), 32'(exp_n(40, 100)));
        check("d60_overlap", 32'(ovl), 32'd0);

        // u_in=200 clamps to 99: low exactly one cycle per period.
        u_in = 15'd200;
        measure(100, -1, 15'd0, hi, nh, ps, ovl, gap, dq0, dq1);
        check("clamp_duty_q", 32'(dq0), 32'd99);
        measure(100, -1, 15'd0, hi, nh, ps, ovl, gap, dq0, dq1);
        check("clamp_hi", 32'(hi), 32'(exp_hi(99)));
        check("clamp_n", 32'(nh), 32'(exp_n(1, 100)));
        check("clamp_gap", 32'(gap), 32'd1);

        // u_in=0: output constantly low.
        u_in = 15'd0;
        measure(100, -1, 15'd0, hi, nh, ps, ovl, gap, dq0, dq1);
        measure(100, -1, 15'd0, hi, nh, ps, ovl, gap, dq0, dq1);
        check("zero_duty_q", 32'(dq0), 32'd0);
        check("zero_hi", 32'(hi), 32'd0);
        check("zero_n", 32'(nh), 32'(exp_n(100, 100)));

        // u_in=5: short pulse (suppressed in the dead-time build).
        u_in = 15'd5;
        measure(100, -1, 15'd0, hi, nh, ps, ovl, gap, dq0, dq1);
        measure(100, -1, 15'd0, hi, nh, ps, ovl, gap, dq0, dq1);
        check("d5_hi", 32'(hi), 32'(exp_hi(5)));
        check("d5_n", 32'(nh), 32'(exp_n(95, 100)));

        // u_in=50: symmetric, no overlap.
        u_in = 15'd50;
        measure(100, -1, 15'd0, hi, nh, ps, ovl, gap, dq0, dq1);
        measure(100, -1, 15'd0, hi, nh, ps, ovl, gap, dq0, dq1);
        check("d50_hi", 32'(hi), 32'(exp_hi(50)));
        check("d50_n", 32'(nh), 32'(exp_n(50, 100)));
        check("d50_overlap", 32'(ovl), 32'd0);
        check("d50_ps_count", 32'(ps), 32'd1);

        // en falls while the output is high: off on the next clock.
        wait_ps(gap);
        repeat (20) @(negedge clk_27);
        check("enfall_pre_pwm", 32'(pwm_out), 32'd1);
        en = 1'b0;
        @(negedge clk_27);
        check("enfall_pwm_out", 32'(pwm_out), 32'd0);
        check("enfall_pwm_n", 32'(pwm_n), 32'd0);
        check("enfall_period_start", 32'(period_start), 32'd0);
        u_in = 15'd30;
        @(negedge clk_27);
        check("enfall_duty_track", 32'(duty_q), 32'd30);
        u_in = 15'd50;

        // Prescaled instance: 40-cycle period, 20 cycles high.
        sel = 1'b1;
        en4 = 1'b1;
        measure(40, -1, 15'd0, hi, nh, ps, ovl, gap, dq0, dq1);
        measure(40, -1, 15'd0, hi, nh, ps, ovl, gap, dq0, dq1);
        check("pre4_gap", 32'(gap), 32'd1);
        check("pre4_hi", 32'(hi), 32'(exp_hi(20)));
        check("pre4_n", 32'(nh), 32'(exp_n(20, 40)));
        check("pre4_ps_count", 32'(ps), 32'd1);
        check("pre4_duty_q", 32'(dq0), 32'd5);
        sel = 1'b0;

        // Asynchronous reset mid-period with the output high.
        en = 1'b1;
        measure(100, -1, 15'd0, hi, nh, ps, ovl, gap, dq0, dq1);
        wait_ps(gap);
        repeat (20) @(negedge clk_27);
        check("arst_pre_pwm", 32'(pwm_out), 32'd1);
        #2;
        areset = 1'b0;
        #1;
        check("arst_pwm_out", 32'(pwm_out), 32'd0);
        check("arst_pwm_n", 32'(pwm_n), 32'd0);
        check("arst_period_start", 32'(period_start), 32'd0);
        check("arst_duty_q", 32'(duty_q), 32'd0);
        @(negedge clk_27);
        areset = 1'b1;
        @(negedge clk_27);
        check("arst_restart_ps", 32'(period_start), 32'd1);
        check("arst_restart_duty", 32'(duty_q), 32'd0);
        measure(100, -1, 15'd0, hi, nh, ps, ovl, gap, dq0, dq1);
        check("arst_restart_gap", 32'(gap), 32'd100);
        check("arst_next_duty", 32'(dq0), 32'd50);
        check("arst_next_hi", 32'(hi), 32'(exp_hi(50)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
